alu_issue_ctrl: RTL and testbench

Issue/writeback controller that is the driving end of the ALU interface. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 16x16 register file. It drives A/B/Opcode/carry-in to the alu, samples C/Flags, then writes back the result register and the processor status register (PSR). It sits between instruction fetch and the existing alu.

---
 rtl/alu_issue_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving an external ALU: latches an instruction, reads
// operands from a 16x16 register file, captures the ALU result and writes back RF/PSR.
// Optional debug read port enabled by defining DBG_RF_PORT_EN.
module alu_issue_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int FLAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [7:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [15:0]       alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] psr_flags,
  output logic              wb_valid,
  output logic [3:0]        wb_reg,
  output logic [15:0]       wb_data,
  output logic              illegal
`ifdef DBG_RF_PORT_EN
  ,
  input  logic [3:0]        dbg_addr,
  output logic [15:0]       dbg_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;
  typedef enum logic [1:0] {B_REG, B_IMM8, B_IMM4} bsel_e;

  state_e              state_q, state_d;
  logic [15:0]         instr_q, instr_d;
  logic [15:0]         rf_q [NUM_REGS];
  logic [15:0]         rf_d [NUM_REGS];
  logic [FLAG_W-1:0]   psr_q, psr_d;
  logic [15:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [7:0]          alu_opcode_q, alu_opcode_d;
  logic                alu_cin_q, alu_cin_d;
  logic [15:0]         res_q, res_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                wb_valid_q, wb_valid_d;
  logic [3:0]          wb_reg_q, wb_reg_d;
  logic [15:0]         wb_data_q, wb_data_d;
  logic                illegal_q, illegal_d;

  logic [3:0] op, ext, rdest, rsrc;
  logic       is_legal, is_psr_upd, is_cmp, is_write;
  bsel_e      b_sel;

  assign op    = instr_q[15:12];
  assign rdest = instr_q[11:8];
  assign ext   = instr_q[7:4];
  assign rsrc  = instr_q[3:0];

  // NOTE: every variable written in an always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    is_legal   = 1'b0;
    is_psr_upd = 1'b0;
    b_sel      = B_IMM8;
    case (op)
      4'h0: begin
        b_sel = B_REG;
        case (ext)
          4'h1, 4'h2, 4'h3, 4'hD: is_legal = 1'b1;
          4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: begin
            is_legal   = 1'b1;
            is_psr_upd = 1'b1;
          end
          default: ;
        endcase
      end
      4'h8: begin
        case (ext)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            is_legal = 1'b1;
            b_sel    = B_IMM4;
          end
          4'h4, 4'h6: begin
            is_legal = 1'b1;
            b_sel    = B_REG;
          end
          default: ;
        endcase
      end
      4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: begin
        is_legal   = 1'b1;
        is_psr_upd = 1'b1;
      end
      4'h1, 4'h2, 4'h3, 4'hD, 4'hF: is_legal = 1'b1;
      default: ;
    endcase
  end

  // Compares only set flags; they never produce a register result.
  assign is_cmp   = (op == 4'hB) || ((op == 4'h0) && (ext == 4'hB));
  assign is_write = is_legal && !is_cmp;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    rf_d         = rf_q;
    psr_d        = psr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    alu_cin_d    = alu_cin_q;
    res_d        = res_q;
    flags_d      = flags_q;
    wb_valid_d   = 1'b0;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;
    illegal_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        alu_a_d      = rf_q[rdest];
        alu_opcode_d = {op, ext};
        alu_cin_d    = psr_q[0];
        case (b_sel)
          B_REG:   alu_b_d = rf_q[rsrc];
          B_IMM4:  alu_b_d = {12'h000, rsrc};
          default: alu_b_d = {8'h00, instr_q[7:0]};
        endcase
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_c;
        flags_d = alu_flags;
        state_d = S_WB;
      end
      S_WB: begin
        if (is_legal) begin
          if (is_write) begin
            rf_d[rdest] = res_q;
            wb_valid_d  = 1'b1;
            wb_reg_d    = rdest;
            wb_data_d   = res_q;
          end
          if (is_psr_upd) psr_d = flags_q;
        end else begin
          illegal_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      // NOTE: the register file is architecturally visible state with a defined
      // reset value, so it is reset here rather than left to a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      psr_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_cin_q    <= 1'b0;
      res_q        <= '0;
      flags_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      rf_q         <= rf_d;
      psr_q        <= psr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      alu_cin_q    <= alu_cin_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      wb_valid_q   <= wb_valid_d;
      wb_reg_q     <= wb_reg_d;
      wb_data_q    <= wb_data_d;
      illegal_q    <= illegal_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_cin     = alu_cin_q;
  assign psr_flags   = psr_q;
  assign wb_valid    = wb_valid_q;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;

`ifdef DBG_RF_PORT_EN
  assign dbg_data = rf_q[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a simple ALU stub answers the DUT, an instruction-level
// model predicts every observable output, and directed tests pin key values.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_opcode;
  logic        alu_cin;
  logic [4:0]  alu_flags, psr_flags;
  logic        wb_valid, illegal;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_cin(alu_cin), .alu_c(alu_c), .alu_flags(alu_flags), .psr_flags(psr_flags),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .illegal(illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in ALU: returns {flags N,Z,F,L,C, result}.
  function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [7:0] opc, input logic cin);
    logic [3:0]  k;
    logic [16:0] s;
    logic [15:0] c;
    logic [4:0]  f;
    logic        ovf;
    k = (opc[7:4] == 4'h0) ? opc[3:0] : opc[7:4];
    s = '0; c = a; f = '0; ovf = 1'b0;
    if (opc[7:4] == 4'h8) c = a << b[3:0];
    else begin
      case (k)
        4'h1: c = a & b;
        4'h2: c = a | b;
        4'h3: c = a ^ b;
        4'hD: c = b;
        4'hF: c = {b[7:0], 8'h00};
        4'h5, 4'h6: s = {1'b0, a} + {1'b0, b};
        4'h7: s = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        4'h9: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        4'hA: s = {1'b0, a} + {1'b0, ~b} + {16'h0, cin};
        4'hB: begin
          c = a - b;
          f = {$signed(a) < $signed(b), a == b, 1'b0, a < b, 1'b0};
        end
        default: c = a;
      endcase
      if (k inside {4'h5, 4'h6, 4'h7}) begin
        c = s[15:0];
        ovf = (a[15] == b[15]) && (c[15] != a[15]);
        f = {c[15], c == 16'h0, ovf, 1'b0, s[16]};
      end else if (k inside {4'h9, 4'hA}) begin
        c = s[15:0];
        ovf = (a[15] != b[15]) && (c[15] != a[15]);
        f = {c[15], c == 16'h0, ovf, 1'b0, s[16]};
      end
    end
    return {f, c};
  endfunction

  always_comb {alu_flags, alu_c} = alu_fn(alu_a, alu_b, alu_opcode, alu_cin);

  // ---------------- instruction-level model ----------------
  logic [15:0] m_rf [16];
  logic [4:0]  m_psr;
  int          m_due = -1;
  int          m_hs_cyc = 0;
  int          m_hs_count = 0;
  logic [15:0] m_instr, e_a, e_b, e_c;
  logic [7:0]  e_opc;
  logic        e_cin, e_legal, e_wr, e_upd;
  logic [4:0]  e_f;

  // {legal, writes register, updates PSR}
  function automatic logic [2:0] classify(input logic [15:0] w);
    logic [3:0] op, ext;
    logic lg, ar, cmp;
    op = w[15:12]; ext = w[7:4];
    lg = ((op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD}))
      || ((op == 4'h8) && (ext inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6}))
      || (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hF});
    ar = ((op == 4'h0) && (ext inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB}))
      || (op inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB});
    cmp = (op == 4'hB) || ((op == 4'h0) && (ext == 4'hB));
    return {lg, lg && !cmp, ar};
  endfunction

  function automatic logic [15:0] operand_b(input logic [15:0] w);
    if (w[15:12] == 4'h0 || (w[15:12] == 4'h8 && (w[7:4] == 4'h4 || w[7:4] == 4'h6)))
      return m_rf[w[3:0]];
    else if (w[15:12] == 4'h8)
      return {12'h000, w[3:0]};
    else
      return {8'h00, w[7:0]};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_psr = '0;
      m_due = -1;
    end else begin
      if (cyc == m_due && e_legal) begin
        if (e_wr) m_rf[m_instr[11:8]] = e_c;
        if (e_upd) m_psr = e_f;
      end
      if (instr_valid && instr_ready) begin
        m_instr = instr;
        m_hs_cyc = cyc - 1;
        m_hs_count++;
        m_due = cyc + 3;
        {e_legal, e_wr, e_upd} = classify(instr);
        e_a   = m_rf[instr[11:8]];
        e_b   = operand_b(instr);
        e_opc = {instr[15:12], instr[7:4]};
        e_cin = m_psr[0];
        {e_f, e_c} = alu_fn(e_a, e_b, e_opc, e_cin);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      logic busy, exp_wb, exp_ill;
      busy    = (m_due >= 0) && (cyc < m_due);
      exp_wb  = (m_due >= 0) && (cyc == m_due) && e_legal && e_wr;
      exp_ill = (m_due >= 0) && (cyc == m_due) && !e_legal;
      check("instr_ready", {31'h0, instr_ready}, {31'h0, !busy});
      if (m_due >= 0 && cyc == m_due - 2) begin
        check("alu_a", {16'h0, alu_a}, {16'h0, e_a});
        check("alu_opcode", {24'h0, alu_opcode}, {24'h0, e_opc});
        check("alu_cin", {31'h0, alu_cin}, {31'h0, e_cin});
        if (e_legal) check("alu_b", {16'h0, alu_b}, {16'h0, e_b});
      end
      check("wb_valid", {31'h0, wb_valid}, {31'h0, exp_wb});
      check("illegal", {31'h0, illegal}, {31'h0, exp_ill});
      if (exp_wb) begin
        check("wb_reg", {28'h0, wb_reg}, {28'h0, m_instr[11:8]});
        check("wb_data", {16'h0, wb_data}, {16'h0, e_c});
      end
      check("psr_flags", {27'h0, psr_flags}, {27'h0, m_psr});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!instr_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("issue_ready", {31'h0, instr_ready}, 32'h1);
    instr_valid = 1'b1;
    instr = w;
    @(negedge clk); #1;
    instr_valid = 1'b0;
    instr = w ^ 16'hA5A5;
  endtask

  task automatic exec_instr(input logic [15:0] w, output int wbn, output int illn,
                            output logic [15:0] wd, output logic [3:0] wr,
                            output int lat, output logic cin_x);
    issue(w);
    wbn = 0; illn = 0; wd = '0; wr = '0; lat = 0; cin_x = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) cin_x = alu_cin;
      if (wb_valid) begin
        wbn++;
        wd = wb_data;
        wr = wb_reg;
        lat = cyc - m_hs_cyc;
      end
      if (illegal) illn++;
    end
  endtask

  logic [15:0] extra [20] = '{
    16'hD37F, 16'h0353, 16'h5305, 16'h9310, 16'h0193, 16'h0A13, 16'h2A0F, 16'h3AF0,
    16'h8313, 16'h8343, 16'h8363, 16'h7300, 16'hA301, 16'h03A1, 16'h00F0, 16'h8050,
    16'hC123, 16'hE456, 16'h03B1, 16'h0000
  };

  initial begin
    int wbn, illn, lat, low, hs0;
    logic [15:0] wd;
    logic [3:0]  wr;
    logic        cx;
    logic [4:0]  psr_save;
    int wb_cycs[$];

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'h0, instr_ready}, 32'h1);
    check("rst_psr", {27'h0, psr_flags}, 32'h0);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst_illegal", {31'h0, illegal}, 32'h0);
    check("rst_alu_a", {16'h0, alu_a}, 32'h0);
    check("rst_alu_b", {16'h0, alu_b}, 32'h0);
    check("rst_alu_op", {24'h0, alu_opcode}, 32'h0);
    check("rst_alu_cin", {31'h0, alu_cin}, 32'h0);
    check("rst_wb_reg", {28'h0, wb_reg}, 32'h0);
    check("rst_wb_data", {16'h0, wb_data}, 32'h0);

    exec_instr(16'hD1FF, wbn, illn, wd, wr, lat, cx);
    check("movi_wbn", wbn, 1);
    check("movi_latency", lat, 4);
    check("movi_reg", {28'h0, wr}, 32'h1);
    check("movi_data", {16'h0, wd}, 32'h00FF);
    check("movi_psr", {27'h0, psr_flags}, 32'h0);

    exec_instr(16'hF2FF, wbn, illn, wd, wr, lat, cx);
    check("lui_data", {16'h0, wd}, 32'hFF00);
    exec_instr(16'h0262, wbn, illn, wd, wr, lat, cx);
    check("addu_data", {16'h0, wd}, 32'hFE00);
    check("addu_carry", {31'h0, psr_flags[0]}, 32'h1);
    exec_instr(16'h0370, wbn, illn, wd, wr, lat, cx);
    check("addc_cin", {31'h0, cx}, 32'h1);
    check("addc_data", {16'h0, wd}, 32'h0001);

    exec_instr(16'hB1FF, wbn, illn, wd, wr, lat, cx);
    check("cmpi_wbn", wbn, 0);
    check("cmpi_z", {31'h0, psr_flags[3]}, 32'h1);
    exec_instr(16'h06D1, wbn, illn, wd, wr, lat, cx);
    check("r1_after_cmpi", {16'h0, wd}, 32'h00FF);

    psr_save = psr_flags;
    exec_instr(16'h4000, wbn, illn, wd, wr, lat, cx);
    check("ill_pulses", illn, 1);
    check("ill_wbn", wbn, 0);
    check("ill_psr", {27'h0, psr_flags}, {27'h0, psr_save});
    exec_instr(16'h07D0, wbn, illn, wd, wr, lat, cx);
    check("r0_after_ill", {16'h0, wd}, 32'h0);

    // Two queued instructions with instr_valid held high.
    @(negedge clk); #1;
    hs0 = m_hs_count;
    instr_valid = 1'b1;
    instr = 16'hD8AA;
    low = 0;
    wb_cycs.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!instr_ready && (m_hs_count - hs0 == 1)) low++;
      if (wb_valid) wb_cycs.push_back(cyc);
      #1;
      if (m_hs_count - hs0 == 1) instr = 16'hD955;
      if (m_hs_count - hs0 == 2) instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
    check("b2b_ready_low", low, 3);
    check("b2b_wb_count", wb_cycs.size(), 2);
    if (wb_cycs.size() == 2) check("b2b_wb_gap", wb_cycs[1] - wb_cycs[0], 4);

    foreach (extra[i]) begin
      exec_instr(extra[i], wbn, illn, wd, wr, lat, cx);
      check("extra_one_event", wbn + illn, {31'h0, classify(extra[i])[1]} + {31'h0, !classify(extra[i])[2]});
    end

    // Reset during EXEC aborts the instruction.
    issue(16'h0151);
    @(negedge clk); #1;
    reset_n = 1'b0;
    wbn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_valid) wbn++;
      #1;
      if (k == 1) reset_n = 1'b1;
    end
    check("rst_mid_wbn", wbn, 0);
    check("rst_mid_ready", {31'h0, instr_ready}, 32'h1);
    check("rst_mid_psr", {27'h0, psr_flags}, 32'h0);
    exec_instr(16'h05D1, wbn, illn, wd, wr, lat, cx);
    check("rst_mid_r1", {16'h0, wd}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
